// File: rtl/eval_pkg.sv
// eval_pkg: shared FSM state type and IEEE-754 single-precision constants
// for the eval_driver custom-instruction sequencer.
package eval_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    localparam logic [31:0] F32_NAN  = 32'h7FC00000;
    localparam logic [31:0] F32_128  = 32'h43000000;
    localparam logic [31:0] F32_HALF = 32'h3F000000;

endpackage

// File: rtl/eval_fifo.sv
// eval_fifo: synchronous operand FIFO; pushes while full and pops while empty are ignored.
module eval_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic        do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = wp == rp;
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= wdata;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop)  rp <= rp + (AW+1)'(1);
        end

endmodule

// File: rtl/eval_driver.sv
// eval_driver: feeds queued float operands one at a time to a custom-instruction evaluator.
// Optional WAIT timeout with NaN result is enabled by defining EVAL_DRIVER_TIMEOUT_EN.
module eval_driver
    import eval_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        ci_start,
    output logic [31:0] ci_dataa,
    input  logic        ci_done,
    input  logic [31:0] ci_result,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0]   head;
    logic          full, empty, pop, to_hit, finish;

    assign pop      = clk_en && state == IDLE && !empty && !out_valid;
    assign in_ready = !full;
    assign busy     = state != IDLE;
    assign ci_start = clk_en && state == ISSUE;

`ifdef EVAL_DRIVER_TIMEOUT_EN
    assign to_hit = state == WAIT && cnt == CW'(TIMEOUT - 1);
`else
    assign to_hit = 1'b0;
`endif
    assign finish = state == WAIT && (ci_done || to_hit);

    eval_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (clk_en && in_valid),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (!empty && !out_valid) ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = finish ? HOLD : WAIT;
            HOLD:    state_nx = (out_valid && out_ready) ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ci_dataa    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            timeout_err <= 1'b0;
        end else if (clk_en) begin
            state <= state_nx;
            // Saturating so the counter can never wrap back under the limit.
            cnt   <= (state == WAIT) ? ((cnt == CW'(TIMEOUT)) ? cnt : cnt + CW'(1)) : '0;
            if (pop) ci_dataa <= head;
            if (finish) begin
                out_valid   <= 1'b1;
                out_data    <= ci_done ? ci_result : F32_NAN;
                timeout_err <= timeout_err | !ci_done;
            end else if (state == HOLD && out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end

endmodule

// File: tb/tb_eval_driver.sv
// tb_eval_driver: directed and random stimulus against a queue-based behavioural model.
module tb_eval_driver;
    import eval_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
`ifdef EVAL_DRIVER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int LAT = TO_EN ? 10 : 40;
    localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_HOLD = 3;

    logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, in_valid = 1'b0;
    logic        ci_done = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0, ci_result = '0;
    logic        in_ready, ci_start, out_valid, busy, timeout_err;
    logic [31:0] ci_dataa, out_data;

    always #5 clk = ~clk;

    eval_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ci_start(ci_start), .ci_dataa(ci_dataa), .ci_done(ci_done), .ci_result(ci_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    logic [31:0] m_q[$];
    int          m_st, m_wait;
    logic [31:0] m_dataa, m_od;
    bit          m_ov, m_terr;
    int          checks = 0, errors = 0;

    logic        g_v = 0, g_done = 0, g_ordy = 0, g_en = 1;
    logic [31:0] g_d = 0, g_res = 0;
    bit          ev_auto = 0;
    int          ev_lat = 3, ev_cnt = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_st = M_IDLE; m_wait = 0; m_dataa = '0; m_od = '0; m_ov = 0; m_terr = 0;
    endfunction

    // One enabled clock edge of the specified behaviour.
    function automatic void model_step(bit en, bit v, logic [31:0] d, bit done, logic [31:0] res, bit ordy);
        bit was_full;
        if (!en) return;
        was_full = m_q.size() == DEPTH;
        case (m_st)
            M_IDLE:  if (m_q.size() > 0 && !m_ov) begin m_dataa = m_q.pop_front(); m_st = M_ISSUE; end
            M_ISSUE: begin m_st = M_WAIT; m_wait = 0; end
            M_WAIT: begin
                m_wait++;
                if (done) begin m_od = res; m_ov = 1; m_st = M_HOLD; end
                else if (TO_EN && m_wait == TIMEOUT) begin m_od = F32_NAN; m_ov = 1; m_terr = 1; m_st = M_HOLD; end
            end
            default: if (m_ov && ordy) begin m_ov = 0; m_st = M_IDLE; end
        endcase
        if (v && !was_full) m_q.push_back(d);
    endfunction

    task automatic compare();
        chk("in_ready", in_ready, m_q.size() < DEPTH);
        chk("ci_start", ci_start, m_st == M_ISSUE && clk_en);
        chk("ci_dataa", ci_dataa, m_dataa);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("busy", busy, m_st != M_IDLE);
        chk("timeout_err", timeout_err, m_terr);
    endtask

    task automatic tick();
        logic        dn;
        logic [31:0] rs;
        dn = g_done; rs = g_res;
        if (ev_auto) begin
            if (ev_cnt > 0) begin
                ev_cnt--;
                if (ev_cnt == 0) begin dn = 1; rs = ~ci_dataa; end
            end
            if (ci_start) ev_cnt = ev_lat;
        end
        clk_en = g_en; in_valid = g_v; in_data = g_d;
        ci_done = dn; ci_result = rs; out_ready = g_ordy;
        model_step(g_en, g_v, g_d, dn, rs, g_ordy);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic pulse_reset();
        rst_n = 0; ci_done = 1; ev_cnt = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ci_start", ci_start, 0);
        chk("rst_ci_dataa", ci_dataa, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_timeout_err", timeout_err, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1; ci_done = 0;
        compare();
    endtask

    task automatic push_one(logic [31:0] d);
        g_v = 1; g_d = d; tick(); g_v = 0;
    endtask

    task automatic wait_start();
        int k = 0;
        while (!ci_start && k < 50) begin tick(); k++; end
        chk("start_seen", ci_start, 1);
    endtask

    logic [31:0] got[$];

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        compare();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);

        // First operand: ci_start two cycles after the push.
        push_one(F32_128);
        chk("start_too_early", ci_start, 0);
        tick();
        chk("start_at_2", ci_start, 1);
        chk("start_dataa", ci_dataa, F32_128);

        // Slow evaluator, then consumer stalls for 5 cycles.
        push_one(32'h11111111);
        repeat (LAT - 2) tick();
        chk("no_early_valid", out_valid, 0);
        g_done = 1; g_res = F32_HALF; tick(); g_done = 0;
        chk("valid_after_done", out_valid, 1);
        chk("half_result", out_data, F32_HALF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_data", out_data, F32_HALF);
            chk("hold_no_start", ci_start, 0);
        end
        g_ordy = 1; tick();
        chk("accepted", out_valid, 0);
        tick();
        chk("next_start", ci_start, 1);
        chk("next_dataa", ci_dataa, 32'h11111111);
        ev_auto = 1; ev_lat = 3;
        repeat (8) tick();

        // Fill the FIFO behind a held result; ninth push is dropped.
        g_ordy = 0;
        push_one(32'h55555555);
        repeat (10) tick();
        chk("fill_hold", out_valid, 1);
        for (int i = 0; i < 8; i++) push_one(32'hA0000000 + i);
        chk("full_ready", in_ready, 0);
        push_one(32'hDEADBEEF);
        chk("full_ready2", in_ready, 0);
        g_ordy = 1;
        for (int t = 0; t < 400 && got.size() < 9; t++) begin
            if (out_valid) got.push_back(out_data);
            tick();
        end
        chk("fill_count", got.size(), 9);
        if (got.size() == 9) begin
            chk("fill_first", got[0], ~32'h55555555);
            for (int i = 0; i < 8; i++) chk("fill_order", got[i+1], ~(32'hA0000000 + i));
        end
        ev_auto = 0; g_ordy = 0;

        // Reset in WAIT abandons the request and drains the FIFO.
        push_one(32'h33333333);
        push_one(32'h44444444);
        wait_start();
        tick();
        pulse_reset();
        g_done = 1; g_res = 32'h12345678; tick(); g_done = 0;
        chk("late_done_ignored", out_valid, 0);
        tick();
        chk("fifo_empty_after_rst", busy, 0);

        // clk_en low holds everything, including through a done pulse.
        push_one(32'h22222222);
        wait_start();
        repeat (2) tick();
        g_en = 0;
        for (int i = 0; i < 10; i++) begin
            g_done = (i % 3 == 0); g_res = 32'h0BADF00D; tick();
        end
        g_done = 0; g_en = 1;
        chk("en_busy", busy, 1);
        chk("en_no_valid", out_valid, 0);
        repeat (20) tick();
        g_done = 1; g_res = 32'h40490FDB; tick(); g_done = 0;
        chk("en_result_valid", out_valid, 1);
        chk("en_result", out_data, TO_EN ? F32_NAN : 32'h40490FDB);
        g_ordy = 1; repeat (2) tick(); g_ordy = 0;

`ifdef EVAL_DRIVER_TIMEOUT_EN
        pulse_reset();
        push_one(32'h66666666);
        wait_start();
        repeat (16) tick();
        chk("to_not_yet", out_valid, 0);
        tick();
        chk("to_valid", out_valid, 1);
        chk("to_nan", out_data, F32_NAN);
        chk("to_err", timeout_err, 1);
        pulse_reset();
        push_one(32'h77777777);
        wait_start();
        repeat (16) tick();
        g_done = 1; g_res = F32_128; tick(); g_done = 0;
        chk("race_valid", out_valid, 1);
        chk("race_data", out_data, F32_128);
        chk("race_err", timeout_err, 0);
`endif

        // Random traffic.
        pulse_reset();
        for (int i = 0; i < 1500; i++) begin
            g_v = $urandom_range(0, 1); g_d = $urandom;
            g_done = $urandom_range(0, 5) == 0; g_res = $urandom;
            g_ordy = $urandom_range(0, 9) < 7; g_en = $urandom_range(0, 9) != 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
